// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, reset PC and FSM state encoding for the fetch stage
package if_fetch_pkg;

    localparam int IF_ADDR_W   = 30;
    localparam int IF_INSN_W   = 32;
    localparam int IF_RESET_PC = 0;

    // ST_HALT is only reachable when SIICPU_IF_FAULT_EN is defined
    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_DROP  = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

endpackage

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with one outstanding imem request
// Optional macro SIICPU_IF_FAULT_EN adds imem_err input and if_fault output.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = IF_ADDR_W,
    parameter int                INSN_W   = IF_INSN_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INSN_W-1:0] imem_rdata,
`ifdef SIICPU_IF_FAULT_EN
    input  logic              imem_err,
    output logic              if_fault,
`endif
    output logic [ADDR_W-1:0] if_pc,
    output logic [INSN_W-1:0] if_insn,
    output logic              if_en
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic [INSN_W-1:0] hold_insn;
    logic              rsp_err;
    logic              rsp_take;

`ifdef SIICPU_IF_FAULT_EN
    assign rsp_err = imem_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_take  = (state == ST_WAIT) && imem_rvalid && !br_taken;
    assign imem_req  = (state == ST_FETCH) && !reset;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_FETCH;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (br_taken) begin
                        pc    <= br_addr;
                        state <= imem_gnt ? ST_DROP : ST_FETCH;
                    end else if (imem_gnt) begin
                        req_pc <= pc;
                        pc     <= pc + ADDR_W'(1);
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // a redirect coincident with the response has nothing left to drop
                    if (br_taken) begin
                        pc    <= br_addr;
                        state <= imem_rvalid ? ST_FETCH : ST_DROP;
                    end else if (imem_rvalid) begin
                        if (rsp_err)
                            state <= ST_HALT;
                        else if (stall)
                            state <= ST_HOLD;
                        else
                            state <= ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (br_taken) begin
                        pc    <= br_addr;
                        state <= ST_FETCH;
                    end else if (!stall) begin
                        state <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (br_taken)
                        pc <= br_addr;
                    if (imem_rvalid)
                        state <= ST_FETCH;
                end
                ST_HALT: begin
                    if (br_taken) begin
                        pc    <= br_addr;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hold_insn <= '0;
        else if (br_taken)
            hold_insn <= '0;
        else if (rsp_take && stall && !rsp_err)
            hold_insn <= imem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_pc   <= '0;
            if_insn <= '0;
            if_en   <= 1'b0;
        end else if (br_taken) begin
            if_en <= 1'b0;
        end else if (rsp_take && rsp_err) begin
            // faulting PC is reported even while downstream is stalled
            if_en <= 1'b0;
            if_pc <= req_pc;
        end else if (!stall) begin
            if (rsp_take) begin
                if_en   <= 1'b1;
                if_pc   <= req_pc;
                if_insn <= imem_rdata;
            end else if (state == ST_HOLD) begin
                if_en   <= 1'b1;
                if_pc   <= req_pc;
                if_insn <= hold_insn;
            end else begin
                if_en <= 1'b0;
            end
        end
    end

`ifdef SIICPU_IF_FAULT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            if_fault <= 1'b0;
        else if (br_taken)
            if_fault <= 1'b0;
        else if (rsp_take && rsp_err)
            if_fault <= 1'b1;
    end
`endif

endmodule
